// File: rtl/mux2_arbiter_24.sv
// Round-robin two-requester arbiter driving the 24-bit 2:1 operand mux.
// Bounded bursts per grant; the selected word is registered onto O.
module mux2_arbiter_24 #(
  parameter int K     = 24,
  parameter int BURST = 4
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic [K-1:0] A,
  input  logic         A_VLD,
  output logic         A_RDY,
  input  logic [K-1:0] B,
  input  logic         B_VLD,
  output logic         B_RDY,
  output logic [K-1:0] O,
  output logic         O_VLD,
  input  logic         O_RDY,
  output logic         SEL
);

  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [BW-1:0] BMAX = BW'(BURST - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [BW-1:0]  bcnt_q, bcnt_d;
  logic           last_q, last_d;
  logic [K-1:0]   o_q, o_d;
  logic           o_vld_q, o_vld_d;

  logic           gnt_a, gnt_b;
  logic           free, beat, rel;
  logic           x_vld, y_vld;
  logic           go, go_b;
  logic [K-1:0]   mux;

  assign gnt_a = (state_q == GNT_A);
  assign gnt_b = (state_q == GNT_B);
  assign free  = !o_vld_q || O_RDY;
  assign mux   = gnt_b ? B : A;
  assign x_vld = gnt_b ? B_VLD : A_VLD;
  assign y_vld = gnt_b ? A_VLD : B_VLD;
  assign beat  = (gnt_a || gnt_b) && x_vld && free;
  assign rel   = (beat && (bcnt_q == BMAX)) || !x_vld;

  assign A_RDY = gnt_a && free;
  assign B_RDY = gnt_b && free;
  assign SEL   = gnt_b;
  assign O     = o_q;
  assign O_VLD = o_vld_q;

  always_comb begin
    state_d = state_q;
    bcnt_d  = beat ? bcnt_q + 1'b1 : bcnt_q;
    last_d  = last_q;
    go      = 1'b0;
    go_b    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // last_q=1 means B went last, so A wins a tie
        if (A_VLD && (!B_VLD || last_q)) begin
          go   = 1'b1;
          go_b = 1'b0;
        end else if (B_VLD) begin
          go   = 1'b1;
          go_b = 1'b1;
        end
      end
      GNT_A, GNT_B: begin
        if (rel) begin
          if (y_vld) begin
            go   = 1'b1;
            go_b = !gnt_b;
          end else if (x_vld) begin
            go   = 1'b1;
            go_b = gnt_b;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (go) begin
      state_d = go_b ? GNT_B : GNT_A;
      bcnt_d  = '0;
      last_d  = go_b;
    end
  end

  always_comb begin
    o_d     = beat ? mux : o_q;
    o_vld_d = o_vld_q;
    if (beat)
      o_vld_d = 1'b1;
    else if (O_RDY)
      o_vld_d = 1'b0;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      bcnt_q  <= '0;
      last_q  <= 1'b1;
      o_q     <= '0;
      o_vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      last_q  <= last_d;
      o_q     <= o_d;
      o_vld_q <= o_vld_d;
    end
  end

endmodule

// File: tb/tb_mux2_arbiter_24.sv
// Directed bench for mux2_arbiter_24: reset, bursts, contention,
// backpressure, withdrawal and mid-burst reset.
module tb_mux2_arbiter_24;

  logic        CLK;
  logic        RST_N;
  logic [23:0] A, B, O;
  logic        A_VLD, A_RDY, B_VLD, B_RDY;
  logic        O_VLD, O_RDY, SEL;

  int total  = 0;
  int passed = 0;
  logic ab, bb;

  mux2_arbiter_24 #(.K(24), .BURST(4)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .A     (A),
    .A_VLD (A_VLD),
    .A_RDY (A_RDY),
    .B     (B),
    .B_VLD (B_VLD),
    .B_RDY (B_RDY),
    .O     (O),
    .O_VLD (O_VLD),
    .O_RDY (O_RDY),
    .SEL   (SEL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed += 1;
    else begin
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; requester data steps after each accepted word
  task automatic tick();
    #4;
    ab = A_VLD && A_RDY;
    bb = B_VLD && B_RDY;
    @(posedge CLK);
    #1;
    if (ab) A = A + 24'd1;
    if (bb) B = B + 24'd1;
  endtask

  initial begin
    logic [23:0] ew;
    int ph, ix;

    // reset with random inputs
    RST_N = 1'b0;
    A = 24'($urandom);
    B = 24'($urandom);
    A_VLD = 1'b1;
    B_VLD = 1'b1;
    O_RDY = 1'($urandom);
    #3;
    chk("rst_O", {8'h0, O}, 32'h0);
    chk("rst_OVLD", {31'h0, O_VLD}, 32'h0);
    chk("rst_SEL", {31'h0, SEL}, 32'h0);
    chk("rst_ARDY", {31'h0, A_RDY}, 32'h0);
    chk("rst_BRDY", {31'h0, B_RDY}, 32'h0);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    chk("rst_hold_OVLD", {31'h0, O_VLD}, 32'h0);
    chk("rst_hold_ARDY", {31'h0, A_RDY}, 32'h0);

    // release, no requests: stays idle
    A_VLD = 1'b0;
    B_VLD = 1'b0;
    O_RDY = 1'b1;
    RST_N = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_ARDY", {31'h0, A_RDY}, 32'h0);
      chk("idle_BRDY", {31'h0, B_RDY}, 32'h0);
      chk("idle_OVLD", {31'h0, O_VLD}, 32'h0);
    end

    // single requester A, 6 words across a burst boundary
    A = 24'h000001;
    A_VLD = 1'b1;
    #1;
    chk("single_idle_ARDY", {31'h0, A_RDY}, 32'h0);
    tick();
    chk("single_gnt_ARDY", {31'h0, A_RDY}, 32'h1);
    chk("single_gnt_OVLD", {31'h0, O_VLD}, 32'h0);
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("single_O", {8'h0, O}, i);
      chk("single_OVLD", {31'h0, O_VLD}, 32'h1);
      chk("single_SEL", {31'h0, SEL}, 32'h0);
    end
    A_VLD = 1'b0;
    tick();
    chk("single_drain_OVLD", {31'h0, O_VLD}, 32'h0);
    chk("single_drain_O", {8'h0, O}, 32'h6);

    // contention from reset: A 2-5, B 6-9, A 10-13
    RST_N = 1'b0;
    A = 24'h000100;
    B = 24'h000200;
    #1;
    RST_N = 1'b1;
    tick();
    A_VLD = 1'b1;
    B_VLD = 1'b1;
    tick();
    for (int c = 2; c <= 13; c++) begin
      ph = (c - 2) / 4;
      ix = (c - 2) % 4;
      chk("cont_SEL", {31'h0, SEL}, (ph == 1) ? 32'h1 : 32'h0);
      chk("cont_ARDY", {31'h0, A_RDY}, (ph == 1) ? 32'h0 : 32'h1);
      chk("cont_BRDY", {31'h0, B_RDY}, (ph == 1) ? 32'h1 : 32'h0);
      if (ph == 1)
        ew = 24'h000200 + 24'(ix);
      else
        ew = 24'h000100 + 24'((ph / 2) * 4 + ix);
      tick();
      chk("cont_O", {8'h0, O}, {8'h0, ew});
    end

    // B burst with backpressure after first beat
    chk("bp_SEL_start", {31'h0, SEL}, 32'h1);
    tick();
    chk("bp_first_O", {8'h0, O}, 32'h204);
    O_RDY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_BRDY", {31'h0, B_RDY}, 32'h0);
      chk("bp_SEL", {31'h0, SEL}, 32'h1);
      chk("bp_O", {8'h0, O}, 32'h204);
      chk("bp_OVLD", {31'h0, O_VLD}, 32'h1);
      chk("bp_BCNT", {30'h0, dut.bcnt_q}, 32'h1);
      tick();
    end
    O_RDY = 1'b1;
    #1;
    chk("bp_resume_BRDY", {31'h0, B_RDY}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      chk("bp_resume_SEL", {31'h0, SEL}, 32'h1);
      tick();
      chk("bp_resume_O", {8'h0, O}, 32'h205 + i);
    end

    // withdrawal: A drops after 2 beats, B takes over
    chk("wd_SEL_A", {31'h0, SEL}, 32'h0);
    tick();
    chk("wd_O1", {8'h0, O}, 32'h108);
    tick();
    chk("wd_O2", {8'h0, O}, 32'h109);
    A_VLD = 1'b0;
    #1;
    chk("wd_drop_SEL", {31'h0, SEL}, 32'h0);
    tick();
    chk("wd_SEL_B", {31'h0, SEL}, 32'h1);
    chk("wd_BRDY", {31'h0, B_RDY}, 32'h1);
    chk("wd_OVLD_gap", {31'h0, O_VLD}, 32'h0);
    A_VLD = 1'b1;
    tick();
    chk("wd_B_O", {8'h0, O}, 32'h208);
    chk("wd_B_hold_SEL", {31'h0, SEL}, 32'h1);
    tick();
    chk("wd_B_O2", {8'h0, O}, 32'h209);

    // reset during beat 3 of an A burst
    RST_N = 1'b0;
    A_VLD = 1'b0;
    B_VLD = 1'b0;
    A = 24'h000300;
    B = 24'h000400;
    #2;
    RST_N = 1'b1;
    A_VLD = 1'b1;
    tick();
    tick();
    tick();
    chk("mr_pre_O", {8'h0, O}, 32'h301);
    chk("mr_pre_OVLD", {31'h0, O_VLD}, 32'h1);
    #2;
    RST_N = 1'b0;
    #1;
    chk("mr_OVLD", {31'h0, O_VLD}, 32'h0);
    chk("mr_O", {8'h0, O}, 32'h0);
    chk("mr_ARDY", {31'h0, A_RDY}, 32'h0);
    #1;
    B_VLD = 1'b1;
    RST_N = 1'b1;
    tick();
    chk("mr_SEL", {31'h0, SEL}, 32'h0);
    chk("mr_ARDY_gnt", {31'h0, A_RDY}, 32'h1);
    chk("mr_BRDY_gnt", {31'h0, B_RDY}, 32'h0);
    tick();
    chk("mr_O_after", {8'h0, O}, 32'h302);
    chk("mr_OVLD_after", {31'h0, O_VLD}, 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mux2_arbiter_24.md
# mux2_arbiter_24

Two-requester arbiter and sequencer for the 24-bit 2:1 operand mux. Requesters A and B each offer 24-bit words on a valid/ready handshake. The block grants one requester at a time in round-robin order, with bounded bursts. It drives the internal mux select and registers the selected word onto a single valid/ready output towards the downstream arithmetic stage.

## Interface
Parameters:
- K, 24, data width of A, B, O.
- BURST, 4, maximum beats per grant (≥1).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- A  in  K  requester A data.
- A_VLD  in  1  requester A word valid.
- A_RDY  out  1  requester A word accepted this cycle when A_VLD=1.
- B  in  K  requester B data.
- B_VLD  in  1  requester B word valid.
- B_RDY  out  1  requester B word accepted this cycle when B_VLD=1.
- O  out  K  registered selected word.
- O_VLD  out  1  O holds a valid word.
- O_RDY  in  1  downstream accepts O this cycle.
- SEL  out  1  mux select (0=A, 1=B), equals current grant.

## Operation
- FSM states: IDLE, GNT_A, GNT_B. Internal registers:
  - BCNT: beats transferred in the current grant, width ceil(log2(BURST)) with a minimum of 1.
  - LAST: side most recently granted.
- Reset values: state=IDLE, BCNT=0, LAST=B (so A wins the first contention), O=0, O_VLD=0. SEL, A_RDY and B_RDY are all 0.
- SEL = (state==GNT_B). The mux output is A when SEL=0, B when SEL=1.
- Output slot free: FREE = !O_VLD || O_RDY.
- Ready signals (combinational):
  - A_RDY = (state==GNT_A) && FREE.
  - B_RDY = (state==GNT_B) && FREE.
  - Neither RDY is ever high in IDLE.
- Beat: the granted side has VLD && RDY. On a beat:
  - O ← mux output.
  - O_VLD ← 1.
  - BCNT ← BCNT+1.
- No beat and O_RDY=1: O_VLD ← 0. O keeps its last value.
- IDLE transitions:
  - A_VLD&&B_VLD: grant the side ≠ LAST.
  - Only one VLD: grant that side.
  - Neither VLD: stay in IDLE.
  - On any grant: BCNT ← 0 and LAST ← granted side.
- GNT_x release (x is the granted side, y the other side) happens when either:
  - a beat occurs with BCNT==BURST-1 (burst exhausted), or
  - x_VLD=0 (requester withdrew).
- GNT_x held (no release) when x_VLD=1 and FREE=0 (backpressure). BCNT is frozen and there is no timeout.
- On release, the next state is:
  - GNT_y if y_VLD.
  - Else GNT_x (new burst) if x_VLD.
  - Else IDLE.
  - BCNT ← 0 and LAST is updated on entering any GNT state.
- Requesters must hold data stable while VLD=1 and RDY=0. Dropping VLD without a beat is legal and releases the grant.
- Data is never dropped or duplicated. Each accepted word appears on O exactly once, with O_VLD=1 until O_RDY.

## Timing
- IDLE→GNT costs 1 cycle. The first beat can occur in the cycle after the request is seen in IDLE.
- Beat-to-O latency is 1 cycle: the word is on O/O_VLD after the edge that accepts it.
- Throughput is 1 word/cycle with O_RDY=1, including across A↔B hand-over. A direct GNT_x→GNT_y switch inserts no bubble.
- A_RDY/B_RDY depend combinationally on O_RDY. There is no combinational path from A_VLD/B_VLD to O.
- Reset mid-burst: the asynchronous assertion immediately forces all reset values. Any word on O is discarded and a partially used burst is forgotten.

## Test plan
- Reset: RST_N=0 with random inputs → O=0, O_VLD=0, SEL=0, A_RDY=B_RDY=0. After release with no VLD, state stays IDLE for 10 cycles.
- Single requester, BURST=4:
  - Stimulus: A_VLD=1 continuously with 6 words 0x000001..0x000006, O_RDY=1.
  - Required: O shows 1..6 on consecutive cycles after a 2-cycle start, with no bubble at the burst boundary (re-grant of A).
- Contention:
  - Stimulus: A_VLD=B_VLD=1 continuously, O_RDY=1, BURST=4, VLD raised 1 cycle after reset release (cycle 1).
  - Required: A beats in cycles 2–5, B in 6–9, A in 10–13. SEL toggles at cycles 6 and 10.
- Backpressure:
  - Stimulus: during a GNT_B burst, O_RDY=0 for 5 cycles.
  - Required: B_RDY=0, O and O_VLD are stable, BCNT is frozen and SEL stays 1. The burst resumes with the remaining beats when O_RDY=1.
- Withdrawal: A_VLD drops after 2 of 4 beats while B_VLD=1 → next cycle SEL=1 and B beats; A's burst is not resumed.
- Reset mid-operation: RST_N pulsed low during beat 3 of an A burst → O_VLD=0 immediately. After release with both requesting, A is granted first (LAST=B).
